// File: rtl/ioshim_alu_seq.sv
// ioshim_alu_seq
//   Issue/writeback sequencer for the ioshim ALU. Accepts one command per
//   valid/ready handshake, reads two operands from a local 8-bit register
//   file, presents them to the ALU (which has a 1-cycle registered result),
//   writes the result back and returns a response. One command in flight.
//
//   Optional build macro: IOSHIM_SEQ_IMM_EN
//     defined   : cmd_imm_sel = 1 selects cmd_imm as op2 (cmd_rs2 ignored)
//     undefined : cmd_imm_sel / cmd_imm unused, op2 always from R[rs2]
//
// Parameters
//   REG_AW : register address width (2**REG_AW entries x 8 bit)
//   WB_R0  : 0 = r0 reads as zero and writes to it are dropped,
//            1 = r0 is an ordinary register
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_insn/rd/rs1/rs2         opcode (0..26 legal), dest and source regs
//   cmd_imm_sel/cmd_imm         immediate operand select / value
//   alu_insn/op1/op2            to the ALU (held outside EXEC)
//   alu_result                  from the ALU, valid the cycle after EXEC
//   rsp_valid/rsp_ready         response handshake
//   rsp_data/rsp_err            result (0 on error) / illegal-opcode flag
//   host_we/waddr/wdata         host register write (applied only in IDLE)
//   host_raddr/host_rdata       combinational host register read
module ioshim_alu_seq #(
    parameter int REG_AW = 3,
    parameter bit WB_R0  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_insn,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic              cmd_imm_sel,
    input  logic [7:0]        cmd_imm,
    output logic [4:0]        alu_insn,
    output logic [7:0]        alu_op1,
    output logic [7:0]        alu_op2,
    input  logic [7:0]        alu_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [7:0]        rsp_data,
    output logic              rsp_err,
    input  logic              host_we,
    input  logic [REG_AW-1:0] host_waddr,
    input  logic [7:0]        host_wdata,
    input  logic [REG_AW-1:0] host_raddr,
    output logic [7:0]        host_rdata
);

    localparam int NREGS = 2 ** REG_AW;
    localparam logic [4:0] INSN_MAX = 5'd26;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_CAPT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_regs [NREGS];
    logic [4:0]        r_alu_insn;
    logic [7:0]        r_alu_op1;
    logic [7:0]        r_alu_op2;
    logic [REG_AW-1:0] r_rd;
    logic              r_err;
    logic [7:0]        r_rsp_data;
    logic              r_rsp_err;

    logic              w_accept;
    logic              w_legal;
    logic [7:0]        w_op1;
    logic [7:0]        w_op2;

    // r0 is hardwired to zero unless WB_R0 makes it a normal register.
    function automatic logic f_r0_locked(input logic [REG_AW-1:0] a);
        return (WB_R0 == 1'b0) && (a == '0);
    endfunction

    function automatic logic [7:0] f_read(input logic [REG_AW-1:0] a);
        if (f_r0_locked(a))
            return 8'h00;
        return r_regs[a];
    endfunction

    assign w_accept   = (r_state == S_IDLE) && cmd_valid;
    assign w_legal    = (cmd_insn <= INSN_MAX);
    assign w_op1      = f_read(cmd_rs1);
    assign host_rdata = f_read(host_raddr);

`ifdef IOSHIM_SEQ_IMM_EN
    assign w_op2 = cmd_imm_sel ? cmd_imm : f_read(cmd_rs2);
`else
    logic w_unused_imm;
    assign w_unused_imm = cmd_imm_sel ^ (^cmd_imm);
    assign w_op2        = f_read(cmd_rs2);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid) w_next = S_EXEC;
            S_EXEC:  w_next = S_CAPT;
            S_CAPT:  w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_alu_insn <= '0;
            r_alu_op1  <= '0;
            r_alu_op2  <= '0;
            r_rd       <= '0;
            r_err      <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            // Operands are taken from the pre-edge register contents, so a
            // host write in the accept cycle is not visible to this command.
            if (w_accept) begin
                r_alu_insn <= w_legal ? cmd_insn : 5'd0;
                r_alu_op1  <= w_op1;
                r_alu_op2  <= w_op2;
                r_rd       <= cmd_rd;
                r_err      <= ~w_legal;
            end
            if (r_state == S_CAPT) begin
                r_rsp_data <= r_err ? 8'h00 : alu_result;
                r_rsp_err  <= r_err;
                if (!r_err && !f_r0_locked(r_rd))
                    r_regs[r_rd] <= alu_result;
            end
            // Host writes only land in IDLE, so they never race writeback.
            if ((r_state == S_IDLE) && host_we && !f_r0_locked(host_waddr))
                r_regs[host_waddr] <= host_wdata;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign alu_insn  = r_alu_insn;
    assign alu_op1   = r_alu_op1;
    assign alu_op2   = r_alu_op2;

endmodule

// File: tb/tb_ioshim_alu_seq.sv
module tb_ioshim_alu_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [4:0] cmd_insn = '0;
    logic [2:0] cmd_rd = '0;
    logic [2:0] cmd_rs1 = '0;
    logic [2:0] cmd_rs2 = '0;
    logic       cmd_imm_sel = 1'b0;
    logic [7:0] cmd_imm = '0;
    logic [4:0] alu_insn;
    logic [7:0] alu_op1;
    logic [7:0] alu_op2;
    logic [7:0] alu_result = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       host_we = 1'b0;
    logic [2:0] host_waddr = '0;
    logic [7:0] host_wdata = '0;
    logic [2:0] host_raddr = '0;
    logic [7:0] host_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } exp_t;
    exp_t sb[$];

    ioshim_alu_seq #(.REG_AW(3), .WB_R0(1'b0)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_insn(cmd_insn), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm_sel(cmd_imm_sel), .cmd_imm(cmd_imm),
        .alu_insn(alu_insn), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .host_raddr(host_raddr), .host_rdata(host_rdata)
    );

    always #5 clk = ~clk;

    // Small ALU model with a registered result (subset of opcodes used here).
    function automatic logic [7:0] alu_f(input logic [4:0] i, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (i)
            5'd0:    return b;
            5'd1:    return s[7:0];
            5'd2:    return a - b;
            5'd18:   return {7'b0, s[8]};
            default: return a ^ b;
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_f(alu_insn, alu_op1, alu_op2);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
        host_we = 1'b1; host_waddr = a; host_wdata = d;
        tick();
        host_we = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        host_raddr = a;
        #1;
        chk(tag, host_rdata, exp);
    endtask

    // Drive a command, push its expected response, return in the EXEC cycle
    // after checking what the ALU is presented with.
    task automatic issue(input string tag, input logic [4:0] insn, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic isel, input logic [7:0] imm,
                         input logic [7:0] e_data, input logic e_err,
                         input logic [4:0] e_ainsn, input logic [7:0] e_op1, input logic [7:0] e_op2);
        exp_t e;
        int   w;
        cmd_insn = insn; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        cmd_imm_sel = isel; cmd_imm = imm; cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin tick(); w++; end
        if (!cmd_ready) chk({tag, "_accept_wait"}, cmd_ready, 1);
        e.data = e_data; e.err = e_err;
        sb.push_back(e);
        tick();
        cmd_valid = 1'b0;
        chk({tag, "_alu_insn"}, alu_insn, e_ainsn);
        chk({tag, "_alu_op1"}, alu_op1, e_op1);
        chk({tag, "_alu_op2"}, alu_op2, e_op2);
    endtask

    task automatic await_rsp(input string tag);
        int cyc;
        cyc = 1;
        while (!rsp_valid && cyc < 12) begin tick(); cyc++; end
        chk({tag, "_rsp_valid"}, rsp_valid, 1);
        chk({tag, "_latency"}, cyc, 3);
    endtask

    // Backpressure with a competing command that must not be accepted.
    task automatic hold(input string tag, input int n);
        logic [7:0] d0;
        logic       e0;
        d0 = rsp_data; e0 = rsp_err;
        cmd_insn = 5'd1; cmd_rd = 3'd7; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_hold_valid"}, rsp_valid, 1);
            chk({tag, "_hold_data"}, rsp_data, d0);
            chk({tag, "_hold_err"}, rsp_err, e0);
            chk({tag, "_hold_cmd_ready"}, cmd_ready, 0);
        end
    endtask

    task automatic finish_rsp(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rsp_data"}, rsp_data, e.data);
            chk({tag, "_rsp_err"}, rsp_err, e.err);
        end
        rsp_ready = 1'b1;
        cmd_valid = 1'b0;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_post_valid"}, rsp_valid, 0);
        chk({tag, "_post_cmd_ready"}, cmd_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_alu_insn", alu_insn, 0);
        chk("rst_alu_op1", alu_op1, 0);
        chk("rst_alu_op2", alu_op2, 0);
        rd_chk("rst_r1", 3'd1, 8'h00);

        // Add: r3 = 5 + 3
        host_wr(3'd1, 8'h05);
        host_wr(3'd2, 8'h03);
        rd_chk("hw_r1", 3'd1, 8'h05);
        issue("add", 5'd1, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'h08, 1'b0, 5'd1, 8'h05, 8'h03);
        await_rsp("add");
        finish_rsp("add");
        rd_chk("add_r3", 3'd3, 8'h08);

        // Sub: r4 = 3 - 5
        issue("sub", 5'd2, 3'd4, 3'd2, 3'd1, 1'b0, 8'h00, 8'hFE, 1'b0, 5'd2, 8'h03, 8'h05);
        await_rsp("sub");
        finish_rsp("sub");
        rd_chk("sub_r4", 3'd4, 8'hFE);

        // Carry out of 0xFF + 0x01
        host_wr(3'd6, 8'hFF);
        host_wr(3'd7, 8'h01);
        issue("cry", 5'd18, 3'd5, 3'd6, 3'd7, 1'b0, 8'h00, 8'h01, 1'b0, 5'd18, 8'hFF, 8'h01);
        await_rsp("cry");
        finish_rsp("cry");
        rd_chk("cry_r5", 3'd5, 8'h01);

        // Backpressure for 5 cycles; blocked command would have written r7
        issue("bp", 5'd1, 3'd3, 3'd1, 3'd1, 1'b0, 8'h00, 8'h0A, 1'b0, 5'd1, 8'h05, 8'h05);
        await_rsp("bp");
        hold("bp", 5);
        finish_rsp("bp");
        rd_chk("bp_r3", 3'd3, 8'h0A);
        rd_chk("bp_r7_untouched", 3'd7, 8'h01);

        // Illegal opcode: no writeback, alu_insn forced to 0
        issue("ill", 5'd27, 3'd5, 3'd1, 3'd2, 1'b0, 8'h00, 8'h00, 1'b1, 5'd0, 8'h05, 8'h03);
        await_rsp("ill");
        finish_rsp("ill");
        rd_chk("ill_r5", 3'd5, 8'h01);

        // r0 is hardwired to zero
        issue("r0wb", 5'd1, 3'd0, 3'd1, 3'd2, 1'b0, 8'h00, 8'h08, 1'b0, 5'd1, 8'h05, 8'h03);
        await_rsp("r0wb");
        finish_rsp("r0wb");
        rd_chk("r0wb_r0", 3'd0, 8'h00);
        host_wr(3'd0, 8'h55);
        rd_chk("r0hw_r0", 3'd0, 8'h00);
        issue("r0rd", 5'd1, 3'd4, 3'd0, 3'd2, 1'b0, 8'h00, 8'h03, 1'b0, 5'd1, 8'h00, 8'h03);
        await_rsp("r0rd");
        finish_rsp("r0rd");
        rd_chk("r0rd_r4", 3'd4, 8'h03);

        // Host write while busy is ignored
        issue("busy", 5'd2, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 8'h02, 1'b0, 5'd2, 8'h05, 8'h03);
        host_we = 1'b1; host_waddr = 3'd2; host_wdata = 8'h77;
        await_rsp("busy");
        host_we = 1'b0;
        finish_rsp("busy");
        rd_chk("busy_r2", 3'd2, 8'h03);
        rd_chk("busy_r3", 3'd3, 8'h02);

        // Host write in the accept cycle: command sees the old r1
        host_we = 1'b1; host_waddr = 3'd1; host_wdata = 8'h10;
        issue("same", 5'd1, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00, 8'h08, 1'b0, 5'd1, 8'h05, 8'h03);
        host_we = 1'b0;
        await_rsp("same");
        finish_rsp("same");
        rd_chk("same_r1", 3'd1, 8'h10);
        rd_chk("same_r6", 3'd6, 8'h08);

`ifdef IOSHIM_SEQ_IMM_EN
        issue("imm", 5'd0, 3'd6, 3'd1, 3'd2, 1'b1, 8'hA5, 8'hA5, 1'b0, 5'd0, 8'h10, 8'hA5);
        await_rsp("imm");
        finish_rsp("imm");
        rd_chk("imm_r6", 3'd6, 8'hA5);
        issue("imm0", 5'd0, 3'd0, 3'd1, 3'd2, 1'b1, 8'hA5, 8'hA5, 1'b0, 5'd0, 8'h10, 8'hA5);
        await_rsp("imm0");
        finish_rsp("imm0");
        rd_chk("imm0_r0", 3'd0, 8'h00);
`endif

        // Reset during EXEC drops the command
        issue("rexec", 5'd1, 3'd7, 3'd1, 3'd2, 1'b0, 8'h00, 8'h13, 1'b0, 5'd1, 8'h10, 8'h03);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb.pop_back());
        chk("rexec_cmd_ready", cmd_ready, 1);
        chk("rexec_rsp_data", rsp_data, 0);
        chk("rexec_alu_insn", alu_insn, 0);
        for (int i = 0; i < 6; i++) begin
            chk("rexec_no_rsp", rsp_valid, 0);
            tick();
        end
        for (int a = 0; a < 8; a++)
            rd_chk("rexec_reg_zero", 3'(a), 8'h00);

        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
